// File: rtl/mac_accumulator.sv
// mac_accumulator
//
// This block drains products from the read side of the MAC async FIFO and adds
// them up in groups of ACC_LEN. Each finished sum is sent out on a valid/ready
// interface. The whole block runs in the FIFO read-clock domain.
//
// Ports:
//   clk        read-domain clock
//   reset      asynchronous reset, active low
//   rEmpty     FIFO empty flag
//   rData      FIFO read data; it is valid on the cycle after rd_En
//   rd_En      FIFO pop request; combinational, so pops can happen on back-to-back cycles
//   clear      synchronous request to abandon the current group
//   acc_out    completed group sum
//   acc_valid  acc_out is valid
//   acc_ready  downstream accepts acc_out
//   overflow   sticky flag: some add in the current group carried out of ACC_WIDTH
//
// Build option:
//   MAC_SAT_EN  When defined, the accumulator clamps to 2^ACC_WIDTH-1 on a carry-out.
//               When undefined, the accumulator wraps modulo 2^ACC_WIDTH.

module mac_accumulator #(
    parameter int WIDTH     = 4,
    parameter int ACC_LEN   = 4,
    parameter int ACC_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rEmpty,
    input  logic [2*WIDTH-1:0]     rData,
    output logic                   rd_En,
    input  logic                   clear,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic                   overflow
);

    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(ACC_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(ACC_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
    logic [CNT_W-1:0]     issued_q, issued_d;
    logic [CNT_W-1:0]     rcvd_q, rcvd_d;
    logic                 rd_pending_q, rd_pending_d;
    logic                 acc_valid_q, acc_valid_d;
    logic                 overflow_q, overflow_d;

    logic [ACC_WIDTH:0]   sum_ext;
    logic                 carry;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 rd_en_c;

    // The reset term makes the pop request drop as soon as reset is asserted,
    // without waiting for the flops to reach their reset state.
    assign rd_en_c = reset & (state_q == ACCUM) & ~rEmpty & (issued_q < LEN_C) & ~clear;

    assign rd_En     = rd_en_c;
    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign overflow  = overflow_q;

    // The adder is one bit wider than the accumulator so the top bit shows the carry-out.
    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, rData};
        carry   = sum_ext[ACC_WIDTH];
`ifdef MAC_SAT_EN
        // A clamped accumulator stays at the maximum value: every later add
        // carries out again, or adds zero and leaves it unchanged.
        acc_next = carry ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
        acc_next = sum_ext[ACC_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_out_d    = acc_out_q;
        issued_d     = issued_q;
        rcvd_d       = rcvd_q;
        acc_valid_d  = acc_valid_q;
        overflow_d   = overflow_q;
        rd_pending_d = rd_en_c;

        if (clear) begin
            // clear has priority over everything else. Data arriving in this
            // cycle is dropped because the add below is skipped.
            state_d     = ACCUM;
            acc_d       = '0;
            issued_d    = '0;
            rcvd_d      = '0;
            acc_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (rd_en_c) begin
                        issued_d = issued_q + CNT_W'(1);
                    end
                    if (rd_pending_q) begin
                        acc_d      = acc_next;
                        overflow_d = overflow_q | carry;
                        rcvd_d     = rcvd_q + CNT_W'(1);
                        if (rcvd_q == LAST_C) begin
                            acc_out_d   = acc_next;
                            acc_valid_d = 1'b1;
                            state_d     = OUT;
                        end
                    end
                end
                OUT: begin
                    if (acc_ready) begin
                        state_d     = ACCUM;
                        acc_d       = '0;
                        issued_d    = '0;
                        rcvd_d      = '0;
                        acc_valid_d = 1'b0;
                        overflow_d  = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            acc_out_q    <= '0;
            issued_q     <= '0;
            rcvd_q       <= '0;
            rd_pending_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_out_q    <= acc_out_d;
            issued_q     <= issued_d;
            rcvd_q       <= rcvd_d;
            rd_pending_q <= rd_pending_d;
            acc_valid_q  <= acc_valid_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator
//
// Testbench for mac_accumulator. The bench itself plays the role of the FIFO:
// it holds a queue of products and returns popped data one cycle after rd_En.
// Two instances share the same stimulus. One uses the default 10-bit
// accumulator. The other uses a 9-bit accumulator so that the overflow path is
// exercised.

module tb_mac_accumulator;

    localparam int WIDTH   = 4;
    localparam int ACC_LEN = 4;
`ifdef MAC_SAT_EN
    localparam int SAT_MODE = 1;
`else
    localparam int SAT_MODE = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rEmpty = 1'b1;
    logic       clear = 1'b0;
    logic       acc_ready = 1'b0;
    logic [7:0] rData = '0;
    logic       rd_En, acc_valid, overflow;
    logic [9:0] acc_out;
    logic       rdEn9, accValid9, overflow9;
    logic [8:0] accOut9;

    always #5 clk = ~clk;

    mac_accumulator #(.WIDTH(WIDTH), .ACC_LEN(ACC_LEN), .ACC_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .rEmpty(rEmpty), .rData(rData), .rd_En(rd_En),
        .clear(clear), .acc_out(acc_out), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .overflow(overflow)
    );

    mac_accumulator #(.WIDTH(WIDTH), .ACC_LEN(ACC_LEN), .ACC_WIDTH(9)) dut9 (
        .clk(clk), .reset(reset), .rEmpty(rEmpty), .rData(rData), .rd_En(rdEn9),
        .clear(clear), .acc_out(accOut9), .acc_valid(accValid9),
        .acc_ready(acc_ready), .overflow(overflow9)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;
    int lastPopCycle = 0;
    int firstValidCycle = 0;
    bit prevValid = 0;
    bit holdEmpty = 0;
    logic [7:0] fifoQ[$];
    logic [7:0] popLog[$];

    bit hsSeen = 0;
    int hsOut, hsOvf, hsOut9, hsOvf9, hsValid9;

    typedef struct {
        logic [7:0] p0, p1, p2, p3;
        int sum10, ovf10, sum9, ovf9;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic updateEmpty();
        rEmpty = holdEmpty || (fifoQ.size() == 0);
    endtask

    // One clock cycle. Outputs are sampled on the falling edge. After the
    // rising edge the FIFO model supplies popped data as registered read data.
    task automatic applyStimulus();
        bit popNow;
        @(negedge clk);
        popNow = rd_En;
        if ((rd_En && rEmpty) || (rd_En !== rdEn9)) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL popRule: rd_En=%0b rdEn9=%0b rEmpty=%0b", rd_En, rdEn9, rEmpty);
        end
        hsSeen = acc_valid && acc_ready;
        if (hsSeen) begin
            hsOut    = int'(acc_out);
            hsOvf    = int'(overflow);
            hsOut9   = int'(accOut9);
            hsOvf9   = int'(overflow9);
            hsValid9 = int'(accValid9);
        end
        if (acc_valid && !prevValid) firstValidCycle = cycleCount + 1;
        prevValid = acc_valid;
        @(posedge clk);
        cycleCount++;
        if (popNow) lastPopCycle = cycleCount;
        #1;
        if (popNow && fifoQ.size() > 0) begin
            rData = fifoQ.pop_front();
            popLog.push_back(rData);
        end
        updateEmpty();
    endtask

    task automatic waitHandshake(input string name);
        int n = 0;
        hsSeen = 0;
        while (!hsSeen && n < 60) begin
            applyStimulus();
            n++;
        end
        if (!hsSeen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (!acc_valid && n < 60) begin
            applyStimulus();
            n++;
        end
        if (!acc_valid) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pushFour(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        fifoQ.push_back(a);
        fifoQ.push_back(b);
        fifoQ.push_back(c);
        fifoQ.push_back(d);
        updateEmpty();
    endtask

    // Reference result for one group, computed with plain integer arithmetic.
    function automatic void groupRef(input int w, input int a, input int b, input int c, input int d,
                                     output int sum, output int ovf);
        int vals[4];
        int lim;
        vals = '{a, b, c, d};
        lim  = 1 << w;
        sum  = 0;
        ovf  = 0;
        foreach (vals[i]) begin
            sum += vals[i];
            if (sum >= lim) begin
                ovf = 1;
                sum = (SAT_MODE != 0) ? lim - 1 : sum - lim;
            end
        end
    endfunction

    initial begin
        int n;
        int handshakes;
        bit bad;
        int eSum, eOvf, eSum9, eOvf9;
        logic [7:0] a, b, c, d;

        vecs[0] = '{8'd6,   8'd20,  8'd35,  8'd100, 161, 0, 161, 0};
        vecs[1] = '{8'd225, 8'd225, 8'd225, 8'd225, 900, 0, (SAT_MODE != 0) ? 511 : 388, 1};
        vecs[2] = '{8'd1,   8'd2,   8'd3,   8'd4,   10,  0, 10,  0};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   0,   0, 0,   0};
        vecs[4] = '{8'd100, 8'd200, 8'd225, 8'd50,  575, 0, (SAT_MODE != 0) ? 511 : 63, 1};
        vecs[5] = '{8'd200, 8'd200, 8'd200, 8'd200, 800, 0, (SAT_MODE != 0) ? 511 : 288, 1};

        // Values held while reset is asserted
        #3;
        checkOutput("resetValid", 32'(acc_valid), 32'd0);
        checkOutput("resetRdEn", 32'(rd_En), 32'd0);
        checkOutput("resetOverflow", 32'(overflow), 32'd0);
        checkOutput("resetAccOut", 32'(acc_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven groups, with acc_ready held high
        acc_ready = 1'b1;
        foreach (vecs[i]) begin
            popLog.delete();
            pushFour(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
            waitHandshake($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_sum10", i), 32'(hsOut), 32'(vecs[i].sum10));
            checkOutput($sformatf("vec%0d_ovf10", i), 32'(hsOvf), 32'(vecs[i].ovf10));
            checkOutput($sformatf("vec%0d_sum9", i), 32'(hsOut9), 32'(vecs[i].sum9));
            checkOutput($sformatf("vec%0d_ovf9", i), 32'(hsOvf9), 32'(vecs[i].ovf9));
            checkOutput($sformatf("vec%0d_valid9", i), 32'(hsValid9), 32'd1);
            if (i == 0) begin
                checkOutput("vec0_latency", 32'(firstValidCycle - lastPopCycle), 32'd2);
                checkOutput("vec0_pops", 32'(popLog.size()), 32'd4);
            end
        end

        // Empty gap in the middle of a group, then a long stall on the output side
        acc_ready = 1'b0;
        popLog.delete();
        fifoQ.push_back(8'd225);
        fifoQ.push_back(8'd225);
        updateEmpty();
        n = 0;
        while (popLog.size() < 2 && n < 20) begin
            applyStimulus();
            n++;
        end
        holdEmpty = 1;
        fifoQ.push_back(8'd225);
        fifoQ.push_back(8'd225);
        updateEmpty();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            if (rd_En !== 1'b0) bad = 1;
        end
        checkOutput("gapNoPop", 32'(bad), 32'd0);
        holdEmpty = 0;
        updateEmpty();
        waitValid("gapGroup");
        checkOutput("gapSum", 32'(acc_out), 32'd900);
        checkOutput("gapOvf", 32'(overflow), 32'd0);
        pushFour(8'd1, 8'd1, 8'd1, 8'd1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus();
            if (acc_out !== 10'd900 || rd_En !== 1'b0 || acc_valid !== 1'b1) bad = 1;
        end
        checkOutput("stallStable", 32'(bad), 32'd0);
        acc_ready = 1'b1;
        applyStimulus();
        checkOutput("stallHandshake", 32'(hsSeen), 32'd1);
        checkOutput("validFalls", 32'(acc_valid), 32'd0);
        checkOutput("bubblePop", 32'(rd_En), 32'd1);
        waitHandshake("afterStall");
        checkOutput("afterStallSum", 32'(hsOut), 32'd4);

        // clear while a read is in flight
        popLog.delete();
        fifoQ.push_back(8'd50);
        fifoQ.push_back(8'd60);
        updateEmpty();
        n = 0;
        while (popLog.size() < 2 && n < 20) begin
            applyStimulus();
            n++;
        end
        clear = 1'b1;
        fifoQ.push_back(8'd7);
        updateEmpty();
        #1;
        checkOutput("clearBlocksPop", 32'(rd_En), 32'd0);
        fifoQ.delete();
        updateEmpty();
        applyStimulus();
        clear = 1'b0;
        checkOutput("clearValid", 32'(acc_valid), 32'd0);
        pushFour(8'd1, 8'd2, 8'd3, 8'd4);
        waitHandshake("afterClear");
        checkOutput("afterClearSum", 32'(hsOut), 32'd10);
        checkOutput("afterClearOvf", 32'(hsOvf), 32'd0);

        // clear while a result is waiting
        acc_ready = 1'b0;
        pushFour(8'd9, 8'd9, 8'd9, 8'd9);
        waitValid("clearOut");
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
        checkOutput("clearOutValid", 32'(acc_valid), 32'd0);
        acc_ready = 1'b1;
        pushFour(8'd1, 8'd1, 8'd1, 8'd1);
        waitHandshake("afterClearOut");
        checkOutput("afterClearOutSum", 32'(hsOut), 32'd4);

        // Asynchronous reset while a result is waiting
        acc_ready = 1'b0;
        pushFour(8'd5, 8'd5, 8'd5, 8'd5);
        waitValid("resetOut");
        fifoQ.push_back(8'd3);
        updateEmpty();
        reset = 1'b0;
        #1;
        checkOutput("asyncResetValid", 32'(acc_valid), 32'd0);
        checkOutput("asyncResetRdEn", 32'(rd_En), 32'd0);
        checkOutput("asyncResetAccOut", 32'(acc_out), 32'd0);
        fifoQ.delete();
        updateEmpty();
        prevValid = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic, checked against the group model
        popLog.delete();
        handshakes = 0;
        for (int k = 0; k < 400; k++) begin
            if (fifoQ.size() < 3 && $urandom_range(0, 1) == 1)
                fifoQ.push_back(8'($urandom_range(0, 15) * $urandom_range(0, 15)));
            holdEmpty = ($urandom_range(0, 5) == 0);
            acc_ready = ($urandom_range(0, 2) != 0);
            updateEmpty();
            applyStimulus();
            if (hsSeen) begin
                handshakes++;
                if (popLog.size() < 4) begin
                    checkOutput("randPopCount", 32'(popLog.size()), 32'd4);
                end else begin
                    a = popLog.pop_front();
                    b = popLog.pop_front();
                    c = popLog.pop_front();
                    d = popLog.pop_front();
                    groupRef(10, int'(a), int'(b), int'(c), int'(d), eSum, eOvf);
                    groupRef(9, int'(a), int'(b), int'(c), int'(d), eSum9, eOvf9);
                    checkOutput("randSum10", 32'(hsOut), 32'(eSum));
                    checkOutput("randOvf10", 32'(hsOvf), 32'(eOvf));
                    checkOutput("randSum9", 32'(hsOut9), 32'(eSum9));
                    checkOutput("randOvf9", 32'(hsOvf9), 32'(eOvf9));
                end
            end
        end
        checkOutput("randGroupsSeen", 32'(handshakes > 5), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Read-side consumer of the MAC async FIFO: pops products from the FIFO read port and sums groups of ACC_LEN products. Each completed sum goes out on a valid/ready interface.
Pairs with the multiplier on the write side: the multiplier produces, this block drains, and the pair forms the full multiply-accumulate path.
Runs entirely in the FIFO read-clock domain.

Parameters:
WIDTH, 4, operand width of the multiplier; product width is 2*WIDTH.
ACC_LEN, 4, products summed per result; legal range 1..256.
ACC_WIDTH, 10, accumulator and result width; must be at least 2*WIDTH.

Ports:
clk  input  1  read-domain clock.
reset  input  1  asynchronous, active-low reset.
rEmpty  input  1  FIFO empty flag, read domain.
rData  input  2*WIDTH  FIFO read data; valid the cycle after rd_En (registered read).
rd_En  output  1  FIFO pop request.
clear  input  1  synchronous abandon of the current group.
acc_out  output  ACC_WIDTH  completed sum.
acc_valid  output  1  acc_out valid.
acc_ready  input  1  downstream accepts acc_out.
overflow  output  1  sticky: current group exceeded ACC_WIDTH.

Behaviour:
- Reset (reset=0, asynchronous): state=ACCUM; rd_En, acc_valid, overflow, acc_out, internal accumulator and counters all 0.
- Internal counters:
  - issued: reads issued in the current group.
  - rcvd: products accumulated.
  - rd_pending: rd_En delayed by one cycle.
- State ACCUM:
  - rd_En = ~rEmpty & (issued < ACC_LEN) & ~clear. Combinational, so back-to-back pops reach one per cycle.
  - rd_pending=1 → acc <= acc + rData, zero-extended to ACC_WIDTH+1 for the carry check; rcvd++.
  - On the last product (rd_pending & rcvd==ACC_LEN-1): acc_out <= final sum, acc_valid <= 1, go to OUT.
  - Latency: the last pop at cycle t gives acc_valid=1 at t+2.
- State OUT:
  - rd_En=0; acc_out held stable while acc_valid=1 & ~acc_ready.
  - acc_ready=1: acc_valid <= 0, acc/issued/rcvd/overflow <= 0, go to ACCUM.
  - The next pop can occur the cycle after handshake, so there is a one-cycle bubble per group.
- rEmpty rising mid-group: stop popping, hold the partial sum, resume when rEmpty falls. No timeout.
- rd_En is never asserted while rEmpty=1. The FIFO is never popped beyond ACC_LEN per group.
- clear=1, any state:
  - rd_En=0 in that cycle.
  - rData arriving that cycle (rd_pending) is discarded.
  - acc, counters, overflow, acc_valid <= 0; state <= ACCUM.
  - clear has priority over acc_ready and over group completion in the same cycle.
- ACC_LEN=1: every pop completes a group; acc_out = zero-extended product.
- Overflow: a carry out of ACC_WIDTH on any add sets overflow=1 until the group is handed off or cleared. overflow is valid alongside acc_valid. Result handling is per MAC_SAT_EN.

Optional Feature:
Macro MAC_SAT_EN.
- Defined: on carry-out the accumulator clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of the group. overflow is still set.
- Undefined: the sum wraps modulo 2^ACC_WIDTH. overflow is still set.

Test Plan:
1. Defaults; reset release; FIFO holds products 6, 20, 35, 100 → exactly 4 single-cycle pops; acc_valid=1 two cycles after the 4th pop; acc_out=161; overflow=0.
2. rEmpty=1 for 5 cycles after the 2nd pop (products 225 ×4) → rd_En stays 0 during the gap; acc_out=900 (fits 10 bits), overflow=0.
3. acc_ready held 0 for 10 cycles in OUT → acc_out stable at 900, rd_En=0 with rEmpty=0; ready=1 → acc_valid falls next cycle; next group starts after one bubble.
4. ACC_WIDTH=9, products 225 ×4 → overflow=1. With MAC_SAT_EN: acc_out=511. Without: acc_out=388.
5. clear pulsed after 2 of 4 pops, with a pop in flight → in-flight datum dropped; next 4 products (1, 2, 3, 4) give acc_out=10.
6. reset asserted while in OUT with acc_valid=1 → acc_valid, rd_En, acc_out go to 0 immediately, without waiting for a clock edge.
